fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Sequences the instruction-fetch stage of the 5-stage pipeline. Owns the PC and drives it
//  into Instr_fetch via reg_we_if. Generates the IF/ID and ID/EX pipeline-register control
//  for load-use stalls, taken-branch redirects and halt/drain.
//  Sits between the ID/EX hazard sources and Instr_fetch.
// PARAMETERS
//  XLEN        32  PC width
//  RESET_PC    0   PC value loaded at reset
//  PC_STEP     4   PC increment per fetched instruction
//  REG_AW      5   register-address width
//  DRAIN_CYC   3   cycles to hold after halt so older instructions retire
//  CNT_W       16  width of saturating performance counters
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       synchronous reset, active-low
//  start           in   1       leave IDLE/HALTED and begin fetching
//  halt_req        in   1       halt instruction decoded in ID
//  id_ex_memread   in   1       ID/EX holds a load
//  id_ex_rd        in   REG_AW  load destination register
//  if_id_rs        in   REG_AW  source register 1 of instruction in ID
//  if_id_rt        in   REG_AW  source register 2 of instruction in ID
//  ex_br_taken     in   1       branch resolved taken in EX
//  ex_br_target    in   XLEN    branch target address
//  reg_we_if       out  XLEN    current PC to Instr_fetch (registered)
//  if_id_write     out  1       1 = IF/ID register captures; 0 = hold
//  if_id_flush     out  1       1 = IF/ID loaded with NOP
//  id_ex_bubble    out  1       1 = ID/EX loaded with NOP
//  halted          out  1       1 while in HALTED
//  stall_cnt       out  CNT_W   load-use stall cycles, saturating
//  flush_cnt       out  CNT_W   redirect events, saturating
// BEHAVIOUR
//  Reset: at the clk edge with rst_n=0: state=IDLE, reg_we_if=RESET_PC, counters=0, drain ctr=0.
//   Comb outputs in IDLE: if_id_write=0, if_id_flush=1, id_ex_bubble=1, halted=0.
//   A mid-operation reset takes effect at the next edge; no pending redirect survives it.
//  States: IDLE, RUN, HALTING, HALTED.
//   IDLE: PC held. start=1 -> RUN. First fetch of RESET_PC occurs in the first RUN cycle.
//   RUN: events are evaluated combinationally each cycle. Priority: redirect > hazard > halt > normal.
//    redirect (ex_br_taken=1):
//     - PC <= ex_br_target.
//     - if_id_flush=1, id_ex_bubble=1, flush_cnt++.
//     - halt_req in the same cycle is ignored (the halt is squashed).
//    hazard (id_ex_memread & id_ex_rd!=0 & (id_ex_rd==if_id_rs | id_ex_rd==if_id_rt)):
//     - PC held, if_id_write=0, id_ex_bubble=1, stall_cnt++.
//     - Re-evaluated next cycle; the ID/EX load has moved on, so this gives exactly a 1-cycle stall.
//    halt (halt_req=1):
//     - PC held, if_id_flush=1, drain ctr <= DRAIN_CYC-1 -> HALTING.
//    normal: PC <= PC+PC_STEP, wrapping mod 2^XLEN (0xFFFFFFFC -> 0x0). if_id_write=1, flush=bubble=0.
//   HALTING:
//    - PC held, if_id_write=0, if_id_flush=1; the drain ctr decrements each cycle.
//    - On ctr==0 -> HALTED.
//    - ex_br_taken=1 in HALTING: an older branch redirects. PC <= target, flush_cnt++, -> RUN.
//   HALTED: halted=1, PC held, if_id_flush=1, id_ex_bubble=1. start=1 -> RUN, resuming at the held PC.
//  Counters saturate at 2^CNT_W-1 and do not wrap.
//  Latency: reg_we_if updates one clk after the controlling input is sampled.
// TESTING
//  1 rst_n=0 for 2 cycles, then start pulse -> reg_we_if sequence 0,4,8,0xC on consecutive cycles; halted=0.
//  2 At PC=0x10: id_ex_memread=1, id_ex_rd=5, if_id_rs=5 for 1 cycle -> PC stays 0x10 one extra cycle;
//    if_id_write=0, id_ex_bubble=1; stall_cnt=1. Same stimulus with rd=0 -> no stall.
//  3 ex_br_taken=1, target=0x100, with hazard and halt_req also set -> next PC=0x100;
//    if_id_flush=1; flush_cnt=1; stall_cnt unchanged; no halt.
//  4 halt_req at PC=0x20 -> PC held at 0x20; HALTING for 3 cycles, then halted=1;
//    start -> fetch resumes at 0x20, then 0x24.
//  5 ex_br_taken=1, target=0x40, in the 2nd HALTING cycle -> next PC=0x40, RUN, halted never asserted.
//  6 Preload PC=0xFFFFFFFC -> next PC 0x0. Force 65536 stalls -> stall_cnt=0xFFFF.
//    rst_n=0 mid-run -> PC=RESET_PC, IDLE, counters 0.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-control bundle: hazard/branch/halt sources from ID/EX plus the PC and
// pipeline-register controls returned to Instr_fetch and the IF/ID, ID/EX registers.
interface fetch_pc_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              halt_req;
    logic              id_ex_memread;
    logic [REG_AW-1:0] id_ex_rd;
    logic [REG_AW-1:0] if_id_rs;
    logic [REG_AW-1:0] if_id_rt;
    logic              ex_br_taken;
    logic [XLEN-1:0]   ex_br_target;
    logic [XLEN-1:0]   reg_we_if;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Controller side: owns the PC and the pipeline-register controls.
    modport master (
        input  start, halt_req, id_ex_memread, id_ex_rd, if_id_rs, if_id_rt,
               ex_br_taken, ex_br_target,
        output reg_we_if, if_id_write, if_id_flush, id_ex_bubble, halted,
               stall_cnt, flush_cnt
    );

    // Pipeline side: supplies hazard sources, consumes the controls.
    modport slave (
        output start, halt_req, id_ex_memread, id_ex_rd, if_id_rs, if_id_rt,
               ex_br_taken, ex_br_target,
        input  reg_we_if, if_id_write, if_id_flush, id_ex_bubble, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: owns the PC, resolves redirect / load-use stall /
// halt events each cycle and drives the IF/ID and ID/EX register controls.
module fetch_pc_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              PC_STEP   = 4,
    parameter int              REG_AW    = 5,
    parameter int              DRAIN_CYC = 3,
    parameter int              CNT_W     = 16
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_ctrl_if.master bus
);
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALTING, HALTED} state_t;

    state_t           state;
    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [DRN_W-1:0] drain;

    logic redirect;
    logic hazard;
    logic wr_c;
    logic flush_c;
    logic bubble_c;
    logic halted_c;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Event detection: a load in EX whose destination feeds the instruction in ID.
    always_comb begin
        redirect = bus.ex_br_taken;
        hazard   = bus.id_ex_memread && (bus.id_ex_rd != '0) &&
                   ((bus.id_ex_rd == bus.if_id_rs) || (bus.id_ex_rd == bus.if_id_rt));
    end

    // Pipeline-register controls for the current cycle; IDLE values are the default.
    always_comb begin
        wr_c     = 1'b0;
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        halted_c = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (hazard) begin
                    flush_c  = 1'b0;
                    bubble_c = 1'b1;
                end else if (bus.halt_req) begin
                    // The halt itself moves on into EX; only younger fetches are squashed.
                    flush_c  = 1'b1;
                    bubble_c = 1'b0;
                end else begin
                    wr_c     = 1'b1;
                    flush_c  = 1'b0;
                    bubble_c = 1'b0;
                end
            end
            HALTING: begin
                // Older instructions keep draining; a late branch also kills ID/EX.
                flush_c  = 1'b1;
                bubble_c = redirect;
            end
            HALTED: begin
                halted_c = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, PC, drain counter and performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            stall_q <= '0;
            flush_q <= '0;
            drain   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // A same-cycle halt belongs to the wrong path and is dropped.
                        pc      <= bus.ex_br_target;
                        flush_q <= sat_inc(flush_q);
                    end else if (hazard) begin
                        stall_q <= sat_inc(stall_q);
                    end else if (bus.halt_req) begin
                        drain <= DRN_W'(DRAIN_CYC - 1);
                        state <= HALTING;
                    end else begin
                        pc <= pc + XLEN'(PC_STEP);
                    end
                end
                HALTING: begin
                    if (redirect) begin
                        pc      <= bus.ex_br_target;
                        flush_q <= sat_inc(flush_q);
                        state   <= RUN;
                    end else if (drain == '0) begin
                        state <= HALTED;
                    end else begin
                        drain <= drain - 1'b1;
                    end
                end
                HALTED: begin
                    if (bus.start) state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.reg_we_if    = pc;
    assign bus.if_id_write  = wr_c;
    assign bus.if_id_flush  = flush_c;
    assign bus.id_ex_bubble = bubble_c;
    assign bus.halted       = halted_c;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed stimulus queues expected values
// tagged with the cycle they must appear in; a negedge monitor compares them.
module tb_fetch_pc_ctrl;
    localparam int S_PC = 0, S_WR = 1, S_FL = 2, S_BUB = 3, S_HLT = 4, S_SC = 5, S_FC = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    fetch_pc_ctrl_if bus();

    fetch_pc_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PC:    return bus.reg_we_if;
            S_WR:    return {31'd0, bus.if_id_write};
            S_FL:    return {31'd0, bus.if_id_flush};
            S_BUB:   return {31'd0, bus.id_ex_bubble};
            S_HLT:   return {31'd0, bus.halted};
            S_SC:    return {16'd0, bus.stall_cnt};
            default: return {16'd0, bus.flush_cnt};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle; stale ones are misses.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                compared++;
                if (sb[i].cyc < cyc) begin
                    mismatched++;
                    $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
                end else if (actual(sb[i].sel) !== sb[i].val) begin
                    mismatched++;
                    $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h",
                             sb[i].name, cyc, actual(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input string name, input int sel, input logic [31:0] val, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.start         = 1'b0;
        bus.halt_req      = 1'b0;
        bus.id_ex_memread = 1'b0;
        bus.id_ex_rd      = '0;
        bus.if_id_rs      = '0;
        bus.if_id_rt      = '0;
        bus.ex_br_taken   = 1'b0;
        bus.ex_br_target  = '0;
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = tgt;
        expect_at("redir_pc", S_PC, tgt, 1);
        step();
        clear_in();
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        step();
        step();

        // Reset state
        expect_at("rst_pc", S_PC, 32'h0, 0);
        expect_at("rst_wr", S_WR, 32'd0, 0);
        expect_at("rst_flush", S_FL, 32'd1, 0);
        expect_at("rst_bubble", S_BUB, 32'd1, 0);
        expect_at("rst_halted", S_HLT, 32'd0, 0);
        expect_at("rst_scnt", S_SC, 32'd0, 0);
        expect_at("rst_fcnt", S_FC, 32'd0, 0);
        rst_n = 1'b1;
        bus.start = 1'b1;
        expect_at("seq_pc0", S_PC, 32'h0, 1);
        expect_at("seq_pc4", S_PC, 32'h4, 2);
        expect_at("seq_pc8", S_PC, 32'h8, 3);
        expect_at("seq_pcC", S_PC, 32'hC, 4);
        expect_at("seq_pc10", S_PC, 32'h10, 5);
        expect_at("run_wr", S_WR, 32'd1, 1);
        expect_at("run_halted", S_HLT, 32'd0, 1);
        step();
        clear_in();
        repeat (4) step();

        // Load-use stall via rs at PC 0x10
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 5'd5;
        bus.if_id_rs = 5'd5;
        expect_at("stall_wr", S_WR, 32'd0, 0);
        expect_at("stall_bubble", S_BUB, 32'd1, 0);
        expect_at("stall_pc_hold", S_PC, 32'h10, 1);
        expect_at("stall_cnt1", S_SC, 32'd1, 1);
        step();
        clear_in();
        expect_at("post_stall_wr", S_WR, 32'd1, 0);
        expect_at("post_stall_pc", S_PC, 32'h14, 1);
        step();

        // rd == 0 never stalls
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 5'd0;
        bus.if_id_rs = 5'd0;
        expect_at("rd0_wr", S_WR, 32'd1, 0);
        expect_at("rd0_bubble", S_BUB, 32'd0, 0);
        expect_at("rd0_pc", S_PC, 32'h18, 1);
        expect_at("rd0_scnt", S_SC, 32'd1, 1);
        step();
        clear_in();

        // Load-use stall via rt
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 5'd7;
        bus.if_id_rt = 5'd7;
        expect_at("rt_wr", S_WR, 32'd0, 0);
        expect_at("rt_pc_hold", S_PC, 32'h18, 1);
        expect_at("rt_scnt", S_SC, 32'd2, 1);
        step();
        clear_in();

        // Redirect beats hazard and halt
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 5'd5;
        bus.if_id_rs = 5'd5;
        bus.halt_req = 1'b1;
        expect_at("br_flush", S_FL, 32'd1, 0);
        expect_at("br_bubble", S_BUB, 32'd1, 0);
        expect_at("br_fcnt", S_FC, 32'd1, 1);
        expect_at("br_scnt_same", S_SC, 32'd2, 1);
        branch_to(32'h100);
        expect_at("br_no_halt_wr", S_WR, 32'd1, 0);
        expect_at("br_next_pc", S_PC, 32'h104, 1);
        step();

        // Halt at 0x20, drain 3 cycles, resume
        branch_to(32'h20);
        bus.halt_req = 1'b1;
        expect_at("halt_flush", S_FL, 32'd1, 0);
        expect_at("halt_pc_hold", S_PC, 32'h20, 1);
        expect_at("drain1_wr", S_WR, 32'd0, 1);
        expect_at("drain1_flush", S_FL, 32'd1, 1);
        expect_at("drain1_halted", S_HLT, 32'd0, 1);
        expect_at("drain2_halted", S_HLT, 32'd0, 2);
        expect_at("drain3_halted", S_HLT, 32'd0, 3);
        expect_at("halted_set", S_HLT, 32'd1, 4);
        expect_at("halted_bubble", S_BUB, 32'd1, 4);
        expect_at("halted_pc", S_PC, 32'h20, 4);
        step();
        clear_in();
        repeat (3) step();
        bus.start = 1'b1;
        expect_at("resume_pc", S_PC, 32'h20, 1);
        expect_at("resume_halted", S_HLT, 32'd0, 1);
        expect_at("resume_next", S_PC, 32'h24, 2);
        step();
        clear_in();
        step();

        // Branch in second HALTING cycle returns to RUN
        bus.halt_req = 1'b1;
        step();
        clear_in();
        step();
        expect_at("hb_halted", S_HLT, 32'd0, 0);
        expect_at("hb_bubble", S_BUB, 32'd1, 0);
        expect_at("hb_fcnt", S_FC, 32'd3, 1);
        expect_at("hb_halted_after", S_HLT, 32'd0, 1);
        branch_to(32'h40);
        expect_at("hb_run_wr", S_WR, 32'd1, 0);
        expect_at("hb_run_pc", S_PC, 32'h44, 1);
        step();

        // PC wrap
        branch_to(32'hFFFF_FFFC);
        expect_at("wrap_pc", S_PC, 32'h0, 1);
        step();

        // Saturate the stall counter
        bus.id_ex_memread = 1'b1;
        bus.id_ex_rd = 5'd5;
        bus.if_id_rs = 5'd5;
        repeat (65540) step();
        expect_at("sat_scnt", S_SC, 32'hFFFF, 1);
        expect_at("sat_pc_hold", S_PC, 32'h0, 1);
        step();
        clear_in();
        repeat (3) step();

        // Mid-run reset with a redirect pending in the same cycle
        expect_at("prerst_pc", S_PC, 32'hC, 0);
        rst_n = 1'b0;
        bus.ex_br_taken = 1'b1;
        bus.ex_br_target = 32'h200;
        expect_at("mrst_pc", S_PC, 32'h0, 1);
        expect_at("mrst_scnt", S_SC, 32'd0, 1);
        expect_at("mrst_fcnt", S_FC, 32'd0, 1);
        step();
        rst_n = 1'b1;
        expect_at("mrst_idle_wr", S_WR, 32'd0, 0);
        expect_at("mrst_idle_flush", S_FL, 32'd1, 0);
        expect_at("mrst_idle_pc", S_PC, 32'h0, 1);
        step();
        clear_in();
        repeat (3) step();

        foreach (sb[i]) begin
            compared++;
            mismatched++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb[i].name, sb[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
